iommu_msi_axi_wr: RTL and testbench



---
 rtl/iommu_msi_pkg.sv | 103 ++++++++++
 rtl/iommu_msi_axi_wr.sv | 152 +++++++++++++++
 tb/tb_iommu_msi_axi_wr.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iommu_msi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iommu_msi_pkg
//  Brief    : Shared FSM states, AXI constants, AXI channel types and the
//             write-strobe helper for the IOMMU MSI write initiator.
//  Revision : 1.0 - initial release
// ============================================================================
package iommu_msi_pkg;

    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_USER_W = 1;

    localparam logic [2:0] AXI_SIZE_32    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_B = 2'd2,
        RESP   = 2'd3
    } msi_state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [AXI_USER_W-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    last;
        logic [AXI_USER_W-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [AXI_USER_W-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [AXI_USER_W-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [AXI_USER_W-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } msi_axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } msi_axi_rsp_t;

    // A 32-bit MSI occupies one half of the 64-bit beat, selected by addr[2]
    function automatic logic [7:0] msi_strb(input logic upper_word);
        return upper_word ? 8'hF0 : 8'h0F;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iommu_msi_axi_wr.sv
`default_nettype none
// ============================================================================
//  Module   : iommu_msi_axi_wr
//  Brief    : Converts a resolved MSI (address, data) into one single-beat
//             32-bit AXI4 write and reports completion/error upstream.
//  Revision : 1.0 - initial release
// ============================================================================
module iommu_msi_axi_wr
    import iommu_msi_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 64,
    parameter int                  DATA_WIDTH = 64,
    parameter int                  ID_WIDTH   = 4,
    parameter int                  USER_WIDTH = 1,
    parameter logic [ID_WIDTH-1:0] MSI_ID     = '0,
    parameter type                 axi_req_t  = iommu_msi_pkg::msi_axi_req_t,
    parameter type                 axi_rsp_t  = iommu_msi_pkg::msi_axi_rsp_t
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  msi_valid_i,
    output logic                  msi_ready_o,
    input  logic [ADDR_WIDTH-1:0] msi_addr_i,
    input  logic [31:0]           msi_data_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  busy_o,
    output axi_req_t              mem_req_o,
    input  axi_rsp_t              mem_resp_i
);

    msi_state_e            r_state;
    msi_state_e            w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_data;
    logic                  r_err;
    logic                  r_aw_sent;
    logic                  r_w_sent;

    logic w_aw_valid;
    logic w_w_valid;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_misaligned;
    logic w_unused;

    assign w_misaligned = (msi_addr_i[1:0] != 2'b00);
    assign w_aw_valid   = (r_state == SEND) && !r_aw_sent;
    assign w_w_valid    = (r_state == SEND) && !r_w_sent;
    assign w_aw_hs      = w_aw_valid && mem_resp_i.aw_ready;
    assign w_w_hs       = w_w_valid && mem_resp_i.w_ready;

    assign w_unused = ^{mem_resp_i.ar_ready, mem_resp_i.r_valid, mem_resp_i.r,
                        mem_resp_i.b.id, mem_resp_i.b.user};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        msi_ready_o  = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        case (r_state)
            IDLE: begin
                msi_ready_o = 1'b1;
                if (msi_valid_i) begin
                    w_next_state = w_misaligned ? RESP : SEND;
                end
            end
            SEND: begin
                busy_o = 1'b1;
                // Either channel may have completed in an earlier cycle
                if ((r_aw_sent || w_aw_hs) && (r_w_sent || w_w_hs)) begin
                    w_next_state = WAIT_B;
                end
            end
            WAIT_B: begin
                busy_o = 1'b1;
                if (mem_resp_i.b_valid) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                done_o       = 1'b1;
                err_o        = r_err;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_aw_sent <= 1'b0;
            r_w_sent  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (msi_valid_i) begin
                        r_addr    <= msi_addr_i;
                        r_data    <= msi_data_i;
                        r_err     <= w_misaligned;
                        r_aw_sent <= 1'b0;
                        r_w_sent  <= 1'b0;
                    end
                end
                SEND: begin
                    if (w_aw_hs) r_aw_sent <= 1'b1;
                    if (w_w_hs)  r_w_sent  <= 1'b1;
                end
                WAIT_B: begin
                    if (mem_resp_i.b_valid) begin
                        r_err <= (mem_resp_i.b.resp != AXI_RESP_OKAY);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_req_o          = '0;
        mem_req_o.aw.id    = MSI_ID;
        mem_req_o.aw.addr  = r_addr;
        mem_req_o.aw.len   = 8'd0;
        mem_req_o.aw.size  = AXI_SIZE_32;
        mem_req_o.aw.burst = AXI_BURST_INCR;
        mem_req_o.aw.user  = {USER_WIDTH{1'b0}};
        mem_req_o.aw_valid = w_aw_valid;
        // Replicate the word so it sits on whichever lane the strobe selects
        mem_req_o.w.data   = {(DATA_WIDTH/32){r_data}};
        mem_req_o.w.strb   = msi_strb(r_addr[2]);
        mem_req_o.w.last   = 1'b1;
        mem_req_o.w.user   = {USER_WIDTH{1'b0}};
        mem_req_o.w_valid  = w_w_valid;
        mem_req_o.b_ready  = (r_state == WAIT_B);
        mem_req_o.ar_valid = 1'b0;
        mem_req_o.r_ready  = 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_iommu_msi_axi_wr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iommu_msi_axi_wr
//  Brief    : Self-checking bench for iommu_msi_axi_wr with a scripted AXI slave.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_iommu_msi_axi_wr;
    import iommu_msi_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         msi_valid = 1'b0;
    logic         msi_ready;
    logic [63:0]  msi_addr = '0;
    logic [31:0]  msi_data = '0;
    logic         done, err, busy;
    msi_axi_req_t mem_req;
    msi_axi_rsp_t mem_resp;

    int n_checks = 0;
    int n_errors = 0;

    // Observations of the most recent transaction
    logic     t_start_ready, t_start_done, t_err, t_leak, t_unstable, t_busy_bad;
    int       t_lat, t_aw_cnt, t_w_cnt, t_aw_cyc, t_w_cyc;
    aw_chan_t t_aw;
    w_chan_t  t_w;

    // Reference expectations
    int       e_lat, e_aw_cyc, e_w_cyc, e_cnt;
    logic     e_err;
    aw_chan_t e_aw;
    w_chan_t  e_w;

    always #5 clk = ~clk;

    iommu_msi_axi_wr dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .msi_valid_i (msi_valid),
        .msi_ready_o (msi_ready),
        .msi_addr_i  (msi_addr),
        .msi_data_i  (msi_data),
        .done_o      (done),
        .err_o       (err),
        .busy_o      (busy),
        .mem_req_o   (mem_req),
        .mem_resp_i  (mem_resp)
    );

    // Expected outcome from the protocol rules: latency is the slower of the
    // two address/data handshakes, plus the B gap, plus the RESP cycle.
    task automatic model(input logic [63:0] a, input logic [31:0] d, input int aw_at,
                         input int w_at, input int b_gap, input logic [1:0] bresp);
        logic mis;
        mis = (a % 4) != 0;
        e_aw = '0;
        e_aw.addr  = a;
        e_aw.size  = 3'd2;
        e_aw.burst = 2'b01;
        e_w = '0;
        e_w.data = {d, d};
        e_w.strb = ((a / 4) % 2 == 1) ? 8'hF0 : 8'h0F;
        e_w.last = 1'b1;
        if (mis) begin
            e_lat = 1; e_err = 1'b1; e_aw_cyc = 0; e_w_cyc = 0; e_cnt = 0;
        end else begin
            e_lat    = ((aw_at > w_at) ? aw_at : w_at) + b_gap + 1;
            e_err    = (bresp != 2'b00);
            e_aw_cyc = aw_at;
            e_w_cyc  = w_at;
            e_cnt    = 1;
        end
    endtask

    // Issue one MSI and act as the AXI slave: AW/W ready from cycle aw_at/w_at
    // after acceptance, B valid b_gap cycles after the later of the two.
    task automatic run_txn(input logic [63:0] a, input logic [31:0] d, input int aw_at,
                           input int w_at, input int b_gap, input logic [1:0] bresp);
        int       aw_hs, w_hs;
        logic     b_done, aw_pend, w_pend;
        aw_chan_t aw_prev;
        w_chan_t  w_prev;
        aw_hs = 0; w_hs = 0; b_done = 0; aw_pend = 0; w_pend = 0;
        aw_prev = '0; w_prev = '0;
        t_lat = -1; t_err = 1'bx; t_aw_cnt = 0; t_w_cnt = 0; t_aw_cyc = 0; t_w_cyc = 0;
        t_leak = 0; t_unstable = 0; t_busy_bad = 0; t_aw = '0; t_w = '0;
        @(negedge clk);
        t_start_ready = msi_ready;
        t_start_done  = done;
        msi_valid = 1'b1; msi_addr = a; msi_data = d;
        @(negedge clk);
        msi_valid = 1'b0; msi_addr = {$urandom, $urandom}; msi_data = $urandom;
        for (int k = 1; k <= 60; k++) begin
            if (mem_req.aw_valid) t_aw_cyc++;
            if (mem_req.w_valid)  t_w_cyc++;
            if (aw_pend && (!mem_req.aw_valid || mem_req.aw !== aw_prev)) t_unstable = 1;
            if (w_pend && (!mem_req.w_valid || mem_req.w !== w_prev))     t_unstable = 1;
            if (msi_ready) t_leak = 1;
            if (busy !== !done) t_busy_bad = 1;
            mem_resp.aw_ready = (k >= aw_at);
            mem_resp.w_ready  = (k >= w_at);
            if (mem_req.aw_valid && mem_resp.aw_ready) begin
                t_aw_cnt++; t_aw = mem_req.aw; aw_hs = k;
            end
            if (mem_req.w_valid && mem_resp.w_ready) begin
                t_w_cnt++; t_w = mem_req.w; w_hs = k;
            end
            aw_pend = mem_req.aw_valid && !mem_resp.aw_ready;
            w_pend  = mem_req.w_valid && !mem_resp.w_ready;
            aw_prev = mem_req.aw;
            w_prev  = mem_req.w;
            mem_resp.b_valid = (aw_hs > 0) && (w_hs > 0) && !b_done &&
                               (k >= ((aw_hs > w_hs) ? aw_hs : w_hs) + b_gap);
            mem_resp.b.resp  = bresp;
            mem_resp.b.id    = AXI_ID_W'($urandom);
            if (mem_resp.b_valid && mem_req.b_ready) b_done = 1;
            if (done) begin
                t_lat = k; t_err = err;
                break;
            end
            @(negedge clk);
        end
        mem_resp.aw_ready = 1'b0;
        mem_resp.w_ready  = 1'b0;
        mem_resp.b_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({msi_ready, mem_req.aw_valid, mem_req.w_valid, mem_req.b_ready, done, err, busy,
             mem_req.ar_valid, mem_req.r_ready} !== 9'b1_0000_0001) begin
            n_errors++;
            $display("FAIL reset_values: got %b required 100000001",
                     {msi_ready, mem_req.aw_valid, mem_req.w_valid, mem_req.b_ready, done, err,
                      busy, mem_req.ar_valid, mem_req.r_ready});
        end
        rst = 1'b0;
    endtask

    task automatic test_aligned();
        model(64'h2400_0000, 32'hDEAD_BEEF, 1, 1, 2, 2'b00);
        run_txn(64'h2400_0000, 32'hDEAD_BEEF, 1, 1, 2, 2'b00);
        n_checks++;
        if (t_aw !== e_aw) begin
            n_errors++; $display("FAIL aligned_aw: got %h required %h", t_aw, e_aw);
        end
        n_checks++;
        if (t_w !== e_w) begin
            n_errors++; $display("FAIL aligned_w: got %h required %h", t_w, e_w);
        end
        n_checks++;
        if (t_lat !== 4 || t_err !== 1'b0) begin
            n_errors++; $display("FAIL aligned_latency: got lat=%0d err=%b required lat=4 err=0", t_lat, t_err);
        end
    endtask

    task automatic test_upper_lane();
        logic [31:0] d;
        d = $urandom;
        run_txn(64'h2400_0004, d, 1, 1, 1, 2'b00);
        n_checks++;
        if ({t_w.strb, t_w.last, t_w.data} !== {8'hF0, 1'b1, d, d}) begin
            n_errors++; $display("FAIL upper_lane_w: got %h required %h", {t_w.strb, t_w.last, t_w.data}, {8'hF0, 1'b1, d, d});
        end
        n_checks++;
        if (t_aw.addr !== 64'h2400_0004) begin
            n_errors++; $display("FAIL upper_lane_addr: got %h required 24000004", t_aw.addr);
        end
    endtask

    task automatic test_skewed();
        run_txn(64'h2400_0008, 32'h1234_5678, 3, 1, 1, 2'b00);
        n_checks++;
        if (t_aw_cyc !== 3 || t_w_cyc !== 1) begin
            n_errors++; $display("FAIL skew_valid_cycles: got aw=%0d w=%0d required aw=3 w=1", t_aw_cyc, t_w_cyc);
        end
        n_checks++;
        if (t_aw_cnt !== 1 || t_w_cnt !== 1) begin
            n_errors++; $display("FAIL skew_beat_count: got aw=%0d w=%0d required 1 1", t_aw_cnt, t_w_cnt);
        end
        n_checks++;
        if ({t_leak, t_unstable, t_busy_bad} !== 3'b000) begin
            n_errors++; $display("FAIL skew_ready_stable: got leak/unstable/busy_bad=%b required 000", {t_leak, t_unstable, t_busy_bad});
        end
        n_checks++;
        if (t_lat !== 5 || t_err !== 1'b0) begin
            n_errors++; $display("FAIL skew_latency: got lat=%0d err=%b required lat=5 err=0", t_lat, t_err);
        end
    endtask

    task automatic test_misaligned();
        run_txn(64'h2400_0002, 32'hCAFE_F00D, 1, 1, 1, 2'b00);
        n_checks++;
        if (t_aw_cyc !== 0 || t_w_cyc !== 0) begin
            n_errors++; $display("FAIL misaligned_bus: got aw_cyc=%0d w_cyc=%0d required 0 0", t_aw_cyc, t_w_cyc);
        end
        n_checks++;
        if (t_lat !== 1 || t_err !== 1'b1) begin
            n_errors++; $display("FAIL misaligned_resp: got lat=%0d err=%b required lat=1 err=1", t_lat, t_err);
        end
    endtask

    task automatic test_error_b2b();
        run_txn(64'h2400_0010, 32'h0000_00AA, 1, 1, 1, 2'b10);
        n_checks++;
        if (t_lat !== 3 || t_err !== 1'b1) begin
            n_errors++; $display("FAIL slverr_resp: got lat=%0d err=%b required lat=3 err=1", t_lat, t_err);
        end
        run_txn(64'h2400_0014, 32'h0000_00BB, 1, 1, 1, 2'b00);
        n_checks++;
        if (t_start_ready !== 1'b1 || t_start_done !== 1'b0) begin
            n_errors++; $display("FAIL b2b_accept: got ready=%b done=%b required ready=1 done=0", t_start_ready, t_start_done);
        end
        n_checks++;
        if (t_lat !== 3 || t_err !== 1'b0) begin
            n_errors++; $display("FAIL b2b_resp: got lat=%0d err=%b required lat=3 err=0", t_lat, t_err);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        msi_valid = 1'b1; msi_addr = 64'h2400_0020; msi_data = 32'h5555_AAAA;
        @(negedge clk);
        msi_valid = 1'b0; mem_resp.aw_ready = 1'b1; mem_resp.w_ready = 1'b1;
        @(negedge clk);
        mem_resp.aw_ready = 1'b0; mem_resp.w_ready = 1'b0;
        n_checks++;
        if (mem_req.b_ready !== 1'b1 || busy !== 1'b1) begin
            n_errors++; $display("FAIL reset_mid_waitb: got b_ready=%b busy=%b required 1 1", mem_req.b_ready, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({msi_ready, mem_req.aw_valid, mem_req.w_valid, mem_req.b_ready, done, err, busy} !== 7'b100_0000) begin
            n_errors++; $display("FAIL reset_mid_values: got %b required 1000000",
                                 {msi_ready, mem_req.aw_valid, mem_req.w_valid, mem_req.b_ready, done, err, busy});
        end
        model(64'h2400_0024, 32'h0BAD_CAFE, 1, 1, 1, 2'b00);
        run_txn(64'h2400_0024, 32'h0BAD_CAFE, 1, 1, 1, 2'b00);
        n_checks++;
        if (t_lat !== e_lat || t_err !== e_err || t_aw !== e_aw || t_w !== e_w) begin
            n_errors++; $display("FAIL reset_mid_recover: got lat=%0d err=%b aw=%h w=%h required lat=%0d err=%b aw=%h w=%h",
                                 t_lat, t_err, t_aw, t_w, e_lat, e_err, e_aw, e_w);
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [31:0] d;
        logic [1:0]  r;
        int          aw_at, w_at, b_gap;
        for (int i = 0; i < 24; i++) begin
            a     = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d     = $urandom;
            r     = 2'($urandom);
            aw_at = $urandom_range(1, 4);
            w_at  = $urandom_range(1, 4);
            b_gap = $urandom_range(1, 3);
            model(a, d, aw_at, w_at, b_gap, r);
            run_txn(a, d, aw_at, w_at, b_gap, r);
            n_checks++;
            if (t_lat !== e_lat || t_err !== e_err) begin
                n_errors++; $display("FAIL rand%0d_resp: got lat=%0d err=%b required lat=%0d err=%b", i, t_lat, t_err, e_lat, e_err);
            end
            n_checks++;
            if (t_aw_cyc !== e_aw_cyc || t_w_cyc !== e_w_cyc || t_aw_cnt !== e_cnt || t_w_cnt !== e_cnt) begin
                n_errors++; $display("FAIL rand%0d_beats: got aw_cyc=%0d w_cyc=%0d aw=%0d w=%0d required %0d %0d %0d %0d",
                                     i, t_aw_cyc, t_w_cyc, t_aw_cnt, t_w_cnt, e_aw_cyc, e_w_cyc, e_cnt, e_cnt);
            end
            n_checks++;
            if ({t_leak, t_unstable, t_busy_bad, t_start_ready} !== 4'b0001) begin
                n_errors++; $display("FAIL rand%0d_handshake: got leak/unstable/busy_bad/ready=%b required 0001",
                                     i, {t_leak, t_unstable, t_busy_bad, t_start_ready});
            end
            if (e_cnt == 1) begin
                n_checks++;
                if (t_aw !== e_aw || t_w !== e_w) begin
                    n_errors++; $display("FAIL rand%0d_payload: got aw=%h w=%h required aw=%h w=%h", i, t_aw, t_w, e_aw, e_w);
                end
            end
        end
    endtask

    initial begin
        mem_resp = '0;
        test_reset();
        test_aligned();
        test_upper_lane();
        test_skewed();
        test_misaligned();
        test_error_b2b();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
